blib_in_fifo: RTL and testbench



---
 rtl/blib_pkg.sv | 13 +
 rtl/blib_in_fifo_ptr.sv | 26 ++
 rtl/blib_in_fifo.sv | 118 +++++++++++
 tb/tb_blib_in_fifo.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/blib_pkg.sv
// Shared types for the blib input path.
// Defines the lala word carried from the producer into blib.
package blib_pkg;

  localparam int LalaWidth = 8;

  typedef logic [LalaWidth-1:0] lala;

  function automatic int usage_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/blib_in_fifo_ptr.sv
// Wrapping FIFO pointer; wraps at Depth-1, so Depth
// need not be a power of two.
module blib_in_fifo_ptr #(
  parameter int Depth = 4,
  localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic                inc_i,
  output logic [PtrWidth-1:0] ptr_o
);

  localparam logic [PtrWidth-1:0] Last = PtrWidth'(Depth - 1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_o <= '0;
    end else if (clr_i) begin
      ptr_o <= '0;
    end else if (inc_i) begin
      ptr_o <= (ptr_o == Last) ? '0 : ptr_o + 1'b1;
    end
  end

endmodule

// File: rtl/blib_in_fifo.sv
// Valid/ready input FIFO feeding blib in_i with occupancy and flush.
// Optional same-cycle bypass when BLIB_IN_FIFO_FALL_THROUGH_EN is defined.
module blib_in_fifo
  import blib_pkg::*;
#(
  parameter int Depth = 4,
  parameter int UsageWidth = usage_width(Depth)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  lala                   data_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output lala                   data_o,
  output logic [UsageWidth-1:0] usage_o
);

  localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [UsageWidth-1:0] Full = UsageWidth'(Depth);

  logic [PtrWidth-1:0]   rptr;
  logic [PtrWidth-1:0]   wptr;
  logic [UsageWidth-1:0] count;
  lala                   mem [Depth];

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic push_q;
  logic pop_q;

  assign full    = (count == Full);
  assign empty   = (count == '0);
  assign ready_o = !full;
  assign usage_o = count;
  assign pop     = !empty && ready_i;

`ifdef BLIB_IN_FIFO_FALL_THROUGH_EN
  logic bypass;

  // A word handed straight through to blib never touches storage.
  assign bypass  = empty && valid_i && !flush_i;
  assign valid_o = !empty || bypass;
  assign push    = valid_i && ready_o && !(bypass && ready_i);

  always_comb begin
    data_o = '0;
    if (bypass) begin
      data_o = data_i;
    end else if (!empty) begin
      data_o = mem[rptr];
    end
  end
`else
  assign valid_o = !empty;
  assign push    = valid_i && ready_o;
  assign data_o  = empty ? '0 : mem[rptr];
`endif

  assign push_q = push && !flush_i;
  assign pop_q  = pop && !flush_i;

  always_ff @(posedge clk_i) begin
    if (push_q) begin
      mem[wptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (flush_i) begin
      count <= '0;
    end else if (push_q && !pop_q) begin
      count <= count + 1'b1;
    end else if (pop_q && !push_q) begin
      count <= count - 1'b1;
    end
  end

  blib_in_fifo_ptr #(
    .Depth (Depth)
  ) u_wptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (flush_i),
    .inc_i (push_q),
    .ptr_o (wptr)
  );

  blib_in_fifo_ptr #(
    .Depth (Depth)
  ) u_rptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (flush_i),
    .inc_i (pop_q),
    .ptr_o (rptr)
  );

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert (Depth >= 2)
        else $error("blib_in_fifo: Depth below 2");
      assert (!(push_q && full))
        else $error("blib_in_fifo: push while full");
      assert (!(pop_q && empty))
        else $error("blib_in_fifo: pop while empty");
    end
  end
`endif

endmodule

// File: tb/tb_blib_in_fifo.sv
// Directed self-checking bench for blib_in_fifo.
// Covers Depth=4 and Depth=3 instances.
module tb_blib_in_fifo;
  import blib_pkg::*;

  logic clk;
  logic rst;

  logic a_flush, a_valid_i, a_ready_i, a_ready_o, a_valid_o;
  lala  a_data_i, a_data_o;
  logic [2:0] a_usage;

  logic b_flush, b_valid_i, b_ready_i, b_ready_o, b_valid_o;
  lala  b_data_i, b_data_o;
  logic [1:0] b_usage;

  int checks = 0;
  int failures = 0;

  blib_in_fifo #(.Depth(4)) dut4 (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (a_flush),
    .valid_i (a_valid_i),
    .ready_o (a_ready_o),
    .data_i  (a_data_i),
    .valid_o (a_valid_o),
    .ready_i (a_ready_i),
    .data_o  (a_data_o),
    .usage_o (a_usage)
  );

  blib_in_fifo #(.Depth(3)) dut3 (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (b_flush),
    .valid_i (b_valid_i),
    .ready_o (b_ready_o),
    .data_i  (b_data_i),
    .valid_o (b_valid_o),
    .ready_i (b_ready_i),
    .data_o  (b_data_o),
    .usage_o (b_usage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push4(input lala d);
    a_valid_i = 1'b1;
    a_data_i  = d;
    step();
  endtask

  initial begin
    rst = 1'b1;
    a_flush = 0; a_valid_i = 0; a_ready_i = 0; a_data_i = '0;
    b_flush = 0; b_valid_i = 0; b_ready_i = 0; b_data_i = '0;
    step();
    step();
    chk("rst_valid", a_valid_o, 0);
    chk("rst_ready", a_ready_o, 1);
    chk("rst_usage", a_usage, 0);
    chk("rst_data", a_data_o, 0);
    rst = 1'b0;
    step();

    // push three, then drain in order
    push4(8'h11);
    chk("lat_valid", a_valid_o, 1);
    chk("lat_data", a_data_o, 8'h11);
    push4(8'h22);
    push4(8'h33);
    a_valid_i = 0;
    chk("t1_usage3", a_usage, 3);
    a_ready_i = 1;
    chk("t1_pop0", a_data_o, 8'h11);
    step();
    chk("t1_pop1", a_data_o, 8'h22);
    step();
    chk("t1_pop2", a_data_o, 8'h33);
    chk("t1_valid_last", a_valid_o, 1);
    step();
    chk("t1_valid_drop", a_valid_o, 0);
    chk("t1_usage0", a_usage, 0);
    chk("t1_data0", a_data_o, 0);
    a_ready_i = 0;

    // fill to full, reject push, pop frees one slot
    for (int i = 0; i < 4; i++) push4(8'hA0 + 8'(i));
    a_valid_i = 0;
    chk("t2_full_ready", a_ready_o, 0);
    chk("t2_full_usage", a_usage, 4);
    push4(8'hFF);
    chk("t2_reject_usage", a_usage, 4);
    chk("t2_reject_head", a_data_o, 8'hA0);
    a_ready_i = 1;
    chk("t2_ready_full_pop", a_ready_o, 0);
    step();
    chk("t2_after_pop_usage", a_usage, 3);
    chk("t2_after_pop_ready", a_ready_o, 1);
    chk("t2_after_pop_head", a_data_o, 8'hA1);
    a_ready_i = 0;
    step();
    a_valid_i = 0;
    chk("t2_ff_accepted", a_usage, 4);
    a_ready_i = 1;
    chk("t2_d1", a_data_o, 8'hA1);
    step();
    chk("t2_d2", a_data_o, 8'hA2);
    step();
    chk("t2_d3", a_data_o, 8'hA3);
    step();
    chk("t2_dff", a_data_o, 8'hFF);
    step();
    chk("t2_empty", a_usage, 0);
    a_ready_i = 0;

    // flush beats a same-cycle push
    push4(8'h01);
    push4(8'h02);
    chk("t4_usage2", a_usage, 2);
    a_flush   = 1;
    a_valid_i = 1;
    a_data_i  = 8'h55;
    step();
    a_flush   = 0;
    a_valid_i = 0;
    chk("t4_usage0", a_usage, 0);
    chk("t4_valid0", a_valid_o, 0);
    chk("t4_data0", a_data_o, 0);
    a_ready_i = 1;
    step();
    chk("t4_no55_valid", a_valid_o, 0);
    chk("t4_no55_data", a_data_o, 0);
    a_ready_i = 0;

    // asynchronous reset mid-stream
    push4(8'h61);
    push4(8'h62);
    push4(8'h63);
    a_valid_i = 0;
    chk("t5_usage3", a_usage, 3);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_valid", a_valid_o, 0);
    chk("t5_async_usage", a_usage, 0);
    chk("t5_async_data", a_data_o, 0);
    chk("t5_async_ready", a_ready_o, 1);
    #1 rst = 1'b0;
    step();
    chk("t5_post_usage", a_usage, 0);

    // empty FIFO, word offered with blib ready
    a_valid_i = 1;
    a_data_i  = 8'h7E;
    a_ready_i = 1;
    #1;
`ifdef BLIB_IN_FIFO_FALL_THROUGH_EN
    chk("ft_valid", a_valid_o, 1);
    chk("ft_data", a_data_o, 8'h7E);
    chk("ft_usage", a_usage, 0);
    step();
    chk("ft_usage_after", a_usage, 0);
`else
    chk("nft_valid", a_valid_o, 0);
    chk("nft_data", a_data_o, 0);
    step();
    a_valid_i = 0;
    chk("nft_valid_next", a_valid_o, 1);
    chk("nft_data_next", a_data_o, 8'h7E);
    chk("nft_usage_next", a_usage, 1);
    step();
    chk("nft_drained", a_usage, 0);
`endif
    a_valid_i = 0;
    a_ready_i = 0;

    // Depth=3 streaming across pointer wrap
    b_valid_i = 1;
    b_ready_i = 1;
    for (int i = 0; i < 20; i++) begin
      b_data_i = 8'h80 + 8'(i);
      step();
      chk($sformatf("t3_data%0d", i), b_data_o, 8'h80 + 8'(i));
      chk($sformatf("t3_valid%0d", i), b_valid_o, 1);
`ifdef BLIB_IN_FIFO_FALL_THROUGH_EN
      chk($sformatf("t3_usage%0d", i), b_usage, 0);
`else
      chk($sformatf("t3_usage%0d", i), b_usage, 1);
`endif
    end
    b_valid_i = 0;
    step();
    chk("t3_end_usage", b_usage, 0);
    chk("t3_end_valid", b_valid_o, 0);
    b_ready_i = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
